// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters, with read-return tagging and write throttling
module bram_port_arbiter #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);
    localparam int CW = $clog2(MAX_WR_BURST + 1);
    localparam logic [CW-1:0] WR_MAX = CW'(MAX_WR_BURST);
    typedef enum logic {ARB, DRAIN} state_t;
    state_t state;
    logic rr_ptr, s1_v, s1_id, s2_v, s2_id, fresh;
    logic sel, any, we_sel, wr_gnt;
    logic [CW-1:0] wr_cnt, wr_next;
    logic [ADDR_WIDTH-1:0] last_addr, addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    always_comb begin
        sel       = (m0_req & m1_req) ? rr_ptr : m1_req;
        any       = rst_n & (state == ARB) & (m0_req | m1_req);
        we_sel    = sel ? m1_we : m0_we;
        addr_sel  = sel ? m1_addr : m0_addr;
        wdata_sel = sel ? m1_wdata : m0_wdata;
        wr_gnt    = any & we_sel;
        wr_next   = !wr_gnt ? '0 : ((s1_v | s2_v) && wr_cnt != WR_MAX) ? wr_cnt + CW'(1) : wr_cnt;
    end
    assign m0_gnt    = any & ~sel;
    assign m1_gnt    = any & sel;
    assign bram_en   = rst_n;
    assign bram_we   = wr_gnt;
    assign bram_addr = !rst_n ? '0 : any ? addr_sel : last_addr;
    assign bram_din  = wr_gnt ? wdata_sel : '0;
    // tag_s2 stays frozen across writes; fresh keeps a held return from being reported twice
    assign m0_rvalid = rst_n & fresh & s2_v & ~s2_id;
    assign m1_rvalid = rst_n & fresh & s2_v & s2_id;
    assign m0_rdata  = bram_dout;
    assign m1_rdata  = bram_dout;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB;
            rr_ptr    <= 1'b0;
            s1_v      <= 1'b0;
            s1_id     <= 1'b0;
            s2_v      <= 1'b0;
            s2_id     <= 1'b0;
            fresh     <= 1'b0;
            wr_cnt    <= '0;
            last_addr <= '0;
        end else begin
            state  <= (state == ARB && wr_next == WR_MAX) ? DRAIN : ARB;
            wr_cnt <= wr_next;
            fresh  <= ~wr_gnt;
            if (any) begin
                rr_ptr    <= ~sel;
                last_addr <= addr_sel;
            end
            if (!wr_gnt) begin
                s1_v  <= any;
                s1_id <= sel;
                s2_v  <= s1_v;
                s2_id <= s1_id;
            end
        end
    end
endmodule
